// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and byte/word helpers.
// Used by both the forward Cipher and the iterative inverse cipher.
package aes_pkg;

  // block[c][r] = byte 4*c+r; element [0][0] is the most significant byte
  typedef logic [0:3][0:3][7:0] aes_block_t;

  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, LAST, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (idx == 4'(k)) r = RCON[4'(k)];
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Row r rotates right by r columns
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[2'(c)][2'(rr)] = s[2'(c - rr)][2'(rr)];
      end
    end
    return r;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[2'(c)][2'(i)];
        m2[i] = xtime(a[i]);
        m4[i] = xtime(m2[i]);
        m8[i] = xtime(m4[i]);
        m9[i] = m8[i] ^ a[i];
        mb[i] = m8[i] ^ m2[i] ^ a[i];
        md[i] = m8[i] ^ m4[i] ^ a[i];
        me[i] = m8[i] ^ m4[i] ^ m2[i];
      end
      r[2'(c)][0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[2'(c)][1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2'(c)][2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[2'(c)][3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

  function automatic aes_block_t key_next(input aes_block_t w, input logic [7:0] rc);
    aes_block_t n;
    n[0] = w[0] ^ sub_word(rot_word(w[3])) ^ {rc, 24'h000000};
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    return n;
  endfunction

  // Undo key_next: recover the previous round key from the current one
  function automatic aes_block_t key_prev(input aes_block_t w, input logic [7:0] rc);
    aes_block_t p;
    p[3] = w[3] ^ w[2];
    p[2] = w[2] ^ w[1];
    p[1] = w[1] ^ w[0];
    p[0] = w[0] ^ sub_word(rot_word(p[3])) ^ {rc, 24'h000000};
    return p;
  endfunction

endpackage

// File: rtl/inv_round_dp.sv
// Combinational inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_round_dp
  import aes_pkg::*;
(
  input  logic [0:3][0:3][7:0] state,
  input  logic [0:3][0:3][7:0] rk,
  input  logic                 last,
  output logic [0:3][0:3][7:0] next_state
);

  logic [0:3][0:3][7:0] shifted;
  logic [0:3][0:3][7:0] subbed;
  logic [0:3][0:3][7:0] keyed;

  assign shifted = inv_shift_rows(state);

  for (genvar gi = 0; gi < 16; gi++) begin : g_isbox
    assign subbed[gi / 4][gi % 4] = INV_SBOX[shifted[gi / 4][gi % 4]];
  end

  assign keyed      = subbed ^ rk;
  assign next_state = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: expands the key forward to round 10, then
// walks it back one round per clock while decrypting.
module inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [0:3][0:3][7:0] key,
  input  logic [0:3][0:3][7:0] data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [0:3][0:3][7:0] o
);

  if (NR != 10) begin : g_bad_nr
    $error("inv_cipher_iter supports only NR=10 (AES-128)");
  end

  fsm_t                 fsm_reg, fsm_next;
  logic [0:3][0:3][7:0] blk_reg, blk_next;
  logic [0:3][0:3][7:0] rk_reg, rk_next;
  logic [3:0]           rnd_reg, rnd_next;
  logic [0:3][0:3][7:0] o_reg, o_next;
  logic                 o_valid_reg, o_valid_next;
  logic                 i_ready_reg, i_ready_next;
  logic [0:3][0:3][7:0] dp_out;
  logic                 dp_last;

  assign dp_last = (fsm_reg == LAST);

  inv_round_dp u_dp (
    .state      (blk_reg),
    .rk         (rk_reg),
    .last       (dp_last),
    .next_state (dp_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg     <= IDLE;
      blk_reg     <= '0;
      rk_reg      <= '0;
      rnd_reg     <= '0;
      o_reg       <= '0;
      o_valid_reg <= 1'b0;
      i_ready_reg <= 1'b0;
    end else begin
      fsm_reg     <= fsm_next;
      blk_reg     <= blk_next;
      rk_reg      <= rk_next;
      rnd_reg     <= rnd_next;
      o_reg       <= o_next;
      o_valid_reg <= o_valid_next;
      i_ready_reg <= i_ready_next;
    end
  end

  always_comb begin
    fsm_next     = fsm_reg;
    blk_next     = blk_reg;
    rk_next      = rk_reg;
    rnd_next     = rnd_reg;
    o_next       = o_reg;
    o_valid_next = o_valid_reg;
    case (fsm_reg)
      IDLE: begin
        // i_ready_reg is low for the first cycle out of reset, so gate on it
        if (i_valid && i_ready_reg) begin
          blk_next = data;
          rk_next  = key;
          rnd_next = 4'd1;
          fsm_next = KEXP;
        end
      end
      KEXP: begin
        rk_next  = key_next(rk_reg, rcon_of(rnd_reg));
        rnd_next = rnd_reg + 4'd1;
        if (rnd_reg == 4'(NR)) fsm_next = ADDK;
      end
      ADDK: begin
        blk_next = blk_reg ^ rk_reg;
        rk_next  = key_prev(rk_reg, rcon_of(4'(NR)));
        rnd_next = 4'(NR - 1);
        fsm_next = ROUND;
      end
      ROUND: begin
        blk_next = dp_out;
        rk_next  = key_prev(rk_reg, rcon_of(rnd_reg));
        rnd_next = rnd_reg - 4'd1;
        if (rnd_reg == 4'd1) fsm_next = LAST;
      end
      LAST: begin
        o_next       = dp_out;
        o_valid_next = 1'b1;
        fsm_next     = DONE;
      end
      DONE: begin
        if (o_ready) begin
          o_valid_next = 1'b0;
          fsm_next     = IDLE;
        end
      end
      default: begin
        o_valid_next = 1'b0;
        fsm_next     = IDLE;
      end
    endcase
    i_ready_next = (fsm_next == IDLE);
  end

  assign i_ready = i_ready_reg;
  assign o_valid = o_valid_reg;
  assign o       = o_reg;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed and round-trip bench for inv_cipher_iter with a queue scoreboard.
module tb_inv_cipher_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic                 i_ready;
  logic [0:3][0:3][7:0] key;
  logic [0:3][0:3][7:0] data;
  logic                 o_valid;
  logic                 o_ready;
  logic [0:3][0:3][7:0] o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int tx = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [7:0]   sb [256];

  inv_cipher_iter #(.NR(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .key     (key),
    .data    (data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o       (o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---- independent forward cipher used only to build round-trip stimulus
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tw;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i - 1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ tw;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4 * ((i / 4 + i % 4) % 4) + i % 4]];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
          s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * rd + i / 4][31 - 8 * (i % 4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // ---- stimulus helpers (leave i_valid high so back-to-back offers work)
  task automatic send(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e);
    int n;
    n = 0;
    key = k;
    data = d;
    i_valid = 1'b1;
    while (!i_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: i_ready stayed 0, required 1");
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    acc_q.push_back(cyc);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk_bit("wait_o_valid", o_valid, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_int("drain_pending", exp_q.size(), 0);
  endtask

  // ---- monitor: latency on each rising o_valid, data on each handshake
  initial begin
    logic ov_prev;
    logic [127:0] e;
    int a;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (o_valid && !ov_prev) begin
          if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: o_valid rose with nothing outstanding, o=%h", o);
          end else begin
            a = acc_q.pop_front();
            chk_int("latency", cyc - a, 21);
          end
        end
        if (o_valid && o_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handshake: o=%h with empty scoreboard", o);
          end else begin
            e = exp_q.pop_front();
            tx++;
            $display("tx %0d: o=%h expected=%h", tx, o, e);
            chk("plaintext", o, e);
          end
        end
      end
      ov_prev = o_valid;
    end
  end

  initial begin
    logic [7:0]   pw;
    logic [127:0] rk, rp;
    int a1, a2;
    for (int x = 0; x < 256; x++) begin
      pw = 8'h01;
      for (int k = 0; k < 254; k++) pw = gm(pw, 8'(x));
      sb[x] = pw ^ rl(pw, 1) ^ rl(pw, 2) ^ rl(pw, 3) ^ rl(pw, 4) ^ 8'h63;
    end

    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    key = '0;
    data = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_i_ready", i_ready, 1'b0);
    chk_bit("reset_o_valid", o_valid, 1'b0);
    chk("reset_o", o, 128'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_bit("i_ready_after_release", i_ready, 1'b1);
    chk("model_fips_b", encrypt(K2, P2), C2);

    // T1 / T2 single blocks
    send(K1, C1, P1); i_valid = 1'b0; drain();
    send(K2, C2, P2); i_valid = 1'b0; drain();

    // T3 backpressure
    o_ready = 1'b0;
    send(K1, C1, P1); i_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_bit("bp_o_valid", o_valid, 1'b1);
      chk("bp_o_stable", o, P1);
      chk_bit("bp_i_ready", i_ready, 1'b0);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk_bit("bp_i_ready_after", i_ready, 1'b1);
    chk_bit("bp_o_valid_after", o_valid, 1'b0);
    chk("o_held_in_idle", o, P1);

    // T4 back-to-back: accept, 21 edges to DONE, one edge to IDLE, then accept
    send(K1, C1, P1); a1 = last_acc;
    send(K2, C2, P2); a2 = last_acc;
    i_valid = 1'b0;
    chk_int("b2b_spacing", a2 - a1, 23);
    drain();

    // T5 reset in ROUND with rnd=5, then a clean T2
    send(K1, C1, P1); i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_bit("rst_round_o_valid", o_valid, 1'b0);
    chk_bit("rst_round_i_ready", i_ready, 1'b0);
    chk("rst_round_o", o, 128'h0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    send(K2, C2, P2); i_valid = 1'b0; drain();

    // reset while a finished block waits in DONE: must vanish at once
    o_ready = 1'b0;
    send(K1, C1, P1); i_valid = 1'b0;
    wait_valid();
    rst = 1'b0;
    #1;
    chk_bit("rst_done_o_valid", o_valid, 1'b0);
    chk("rst_done_o", o, 128'h0);
    exp_q.delete();
    acc_q.delete();
    o_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_bit("rst_done_i_ready", i_ready, 1'b1);

    // T6 round trip through the forward model
    for (int n = 0; n < 30; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      send(rk, encrypt(rk, rp), rp);
    end
    i_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
